// File: rtl/bit_recovery.sv
// bit_recovery: syncs the raw NRZ line, recovers bit timing from transitions, strobes each bit and flags the inter-frame idle gap.
// First strobe 3+CLKS_PER_BIT/2 cycles after a line transition (+2 with BIT_RECOVERY_GLITCH_FILTER_EN); no backpressure.
module bit_recovery #(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 32,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_raw,
  input  logic       enable,
  output logic       serial_data,
  output logic       serial_clock,
  output logic       frame_active,
  output logic       frame_end,
  output logic [7:0] bit_count
);

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] PHASE_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, LOCK} state_t;

  logic sync_0;
  logic rx_s;
  logic rx_f;
  logic rx_prev;
  logic edge_q;

  // The edge flag is registered: it is the one-cycle "edge" stage of the first-strobe latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0  <= 1'b0;
      rx_s    <= 1'b0;
      rx_prev <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_0  <= rx_raw;
      rx_s    <= sync_0;
      rx_prev <= rx_f;
      edge_q  <= rx_f ^ rx_prev;
    end
  end

`ifdef BIT_RECOVERY_GLITCH_FILTER_EN
  logic filt_a;
  logic filt_q;

  // Majority of (current, previous, filtered) rejects single-cycle pulses at two cycles of lag.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_a <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      filt_a <= rx_s;
      filt_q <= (rx_s & filt_a) | (rx_s & filt_q) | (filt_a & filt_q);
    end
  end

  assign rx_f = filt_q;
`else
  assign rx_f = rx_s;
`endif

  state_t           state;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_nxt;

  assign idle_nxt = idle_cnt + CNT_ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      idle_cnt     <= '0;
      serial_data  <= 1'b0;
      serial_clock <= 1'b0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      bit_count    <= 8'd0;
    end else begin
      serial_clock <= 1'b0;
      frame_end    <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        phase        <= '0;
        idle_cnt     <= '0;
        bit_count    <= 8'd0;
        frame_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (edge_q) begin
              state        <= LOCK;
              frame_active <= 1'b1;
              phase        <= '0;
              idle_cnt     <= '0;
              bit_count    <= 8'd0;
            end
          end
          LOCK: begin
            phase <= (phase == PHASE_MAX) ? '0 : phase + CNT_ONE;
            if (edge_q) begin
              phase    <= '0;
              idle_cnt <= '0;
            end else if (phase == HALF_M1) begin
              serial_clock <= 1'b1;
              serial_data  <= rx_f;
              if (bit_count != 8'hFF) bit_count <= bit_count + 8'd1;
              idle_cnt <= idle_nxt;
              // The final strobe and frame_end share a cycle; the decoder takes the bit first.
              if (idle_nxt == IDLE_LIM) begin
                frame_end    <= 1'b1;
                frame_active <= 1'b0;
                state        <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_recovery.sv
// tb_bit_recovery: random and directed NRZ streams against an event-level model of bit recovery.
module tb_bit_recovery;

  localparam int CPB       = 16;
  localparam int HALF      = CPB / 2;
  localparam int IDLE_BITS = 32;
  localparam int MAXC      = 8192;
`ifdef BIT_RECOVERY_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 13;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 11;
`endif
  localparam int A = LAT - HALF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_raw = 1'b0;
  logic       enable = 1'b1;
  logic       serial_data;
  logic       serial_clock;
  logic       frame_active;
  logic       frame_end;
  logic [7:0] bit_count;

  int errors = 0;
  int checks = 0;

  bit          line [MAXC];
  bit          en_v [MAXC];
  bit          rst_v[MAXC];
  int          nline;
  logic [11:0] rec  [MAXC];
  logic [11:0] expv [MAXC];
  bit          frame[256];
  bit          m_lv [MAXC];
  bit          m_sc [MAXC];
  bit          m_sd [MAXC];
  bit          m_fe [MAXC];
  bit          m_fa [MAXC];
  int          m_bc [MAXC];
  int          st[$];

  always #5 clock = ~clock;

  bit_recovery #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .rx_raw(rx_raw), .enable(enable),
    .serial_data(serial_data), .serial_clock(serial_clock),
    .frame_active(frame_active), .frame_end(frame_end), .bit_count(bit_count)
  );

  function automatic logic [11:0] sample_obs();
    return {serial_clock, serial_clock & serial_data, frame_end, frame_active, bit_count};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; rx_raw = 1'b0; enable = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_stim();
    nline = 0;
    for (int i = 0; i < MAXC; i++) begin
      line[i] = 1'b0; en_v[i] = 1'b1; rst_v[i] = 1'b0;
    end
  endtask

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) begin line[nline] = v; nline++; end
  endtask

  task automatic add_bits(input int per, input int nb);
    for (int b = 0; b < nb; b++) add_level(frame[b], per);
  endtask

  task automatic gen_frame(input int nb, input int maxrun);
    int run;
    bit v;
    frame[0] = 1'b1;
    run = 1;
    for (int b = 1; b < nb; b++) begin
      v = 1'($urandom % 2);
      if (v == frame[b-1]) run++; else run = 1;
      if (run > maxrun) begin v = ~frame[b-1]; run = 1; end
      frame[b] = v;
    end
  endtask

  // rec[p] holds the outputs registered on the posedge that samples line[p].
  task automatic play();
    for (int i = 0; i <= nline; i++) begin
      @(negedge clock);
      if (i > 0) rec[i-1] = sample_obs();
      if (i < nline) begin
        rx_raw = line[i]; enable = en_v[i]; reset = rst_v[i];
      end
    end
    reset = 1'b0; enable = 1'b1;
    st.delete();
    for (int i = 0; i < nline; i++) if (rec[i][11] === 1'b1) st.push_back(i);
  endtask

  // Model: each line transition, seen A cycles later, restarts bit timing; strobes fall HALF
  // cycles later and every CPB thereafter until the next transition lands, and the 32nd
  // strobe after a transition closes the frame.
  task automatic build_expected();
    int  tr[$];
    int  act, nact, s, bc, cur;
    bit  locked, prev;
    for (int i = 0; i < nline; i++) begin
      m_lv[i] = line[i];
      if (FILT && i + 1 < nline) begin
        prev = (i > 0) ? line[i-1] : 1'b0;
        if (line[i] != prev && line[i+1] == prev) m_lv[i] = prev;
      end
      m_sc[i] = 0; m_sd[i] = 0; m_fe[i] = 0; m_fa[i] = 0; m_bc[i] = -1;
    end
    prev = 1'b0;
    for (int i = 0; i < nline; i++) begin
      if (m_lv[i] != prev) tr.push_back(i);
      prev = m_lv[i];
    end
    bc = 0; locked = 0;
    for (int t = 0; t < tr.size(); t++) begin
      act  = tr[t] + A;
      nact = (t + 1 < tr.size()) ? tr[t+1] + A : 2 * MAXC;
      if (act >= nline) break;
      if (!locked) begin
        locked = 1; bc = 0; m_bc[act] = 0;
        for (int j = act; j < nline; j++) m_fa[j] = 1;
      end
      for (int k = 0; k < IDLE_BITS; k++) begin
        s = act + HALF + k * CPB;
        if (s >= nact || s >= nline) break;
        bc = (bc < 255) ? bc + 1 : 255;
        m_sc[s] = 1; m_sd[s] = m_lv[s - A + 1]; m_bc[s] = bc;
        if (k == IDLE_BITS - 1) begin
          m_fe[s] = 1; locked = 0;
          for (int j = s; j < nline; j++) m_fa[j] = 0;
        end
      end
    end
    cur = 0;
    for (int i = 0; i < nline; i++) begin
      if (m_bc[i] >= 0) cur = m_bc[i];
      expv[i] = {m_sc[i], m_sc[i] & m_sd[i], m_fe[i], m_fa[i], 8'(cur)};
    end
  endtask

  function automatic int last_edge_bit(input int nb);
    int lt = 0;
    for (int b = 1; b < nb; b++) if (frame[b] != frame[b-1]) lt = b;
    return lt;
  endfunction

  task automatic test_reset();
    int nerr = 0;
    @(negedge clock);
    reset = 1'b1; rx_raw = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (serial_clock !== 1'b0) begin errors++; $display("FAIL reset_serial_clock got=%b want=0", serial_clock); end
    checks++; if (serial_data !== 1'b0) begin errors++; $display("FAIL reset_serial_data got=%b want=0", serial_data); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b want=0", frame_active); end
    checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end got=%b want=0", frame_end); end
    checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL reset_bit_count got=%0d want=0", bit_count); end
    reset = 1'b0;
    clear_stim(); add_level(1'b0, 300);
    play(); build_expected();
    for (int i = 0; i < nline && nerr < 6; i++) begin
      checks++;
      if (rec[i] !== expv[i]) begin errors++; nerr++; $display("FAIL idle_trace cyc=%0d got=%h want=%h", i, rec[i], expv[i]); end
    end
  endtask

  task automatic test_alternating();
    int nerr = 0;
    do_reset(); clear_stim();
    for (int b = 0; b < 32; b++) frame[b] = (b % 2 == 0);
    add_level(1'b0, 40); add_bits(CPB, 32); add_level(1'b0, 40 * CPB);
    play(); build_expected();
    checks++;
    if (st.size() != 31 + IDLE_BITS) begin errors++; $display("FAIL alt_strobe_total got=%0d want=%0d", st.size(), 31 + IDLE_BITS); end
    if (st.size() >= 32) begin
      checks++;
      if (st[0] != 40 + LAT) begin errors++; $display("FAIL alt_first_latency got=%0d want=%0d", st[0] - 40, LAT); end
      for (int j = 0; j < 32; j++) begin
        checks++;
        if (rec[st[j]][10] !== frame[j]) begin errors++; $display("FAIL alt_bit%0d got=%b want=%b", j, rec[st[j]][10], frame[j]); end
      end
      checks++;
      if (rec[st[31]][7:0] !== 8'd32) begin errors++; $display("FAIL alt_bit_count got=%0d want=32", rec[st[31]][7:0]); end
    end
    for (int i = 0; i < nline && nerr < 6; i++) begin
      checks++;
      if (rec[i] !== expv[i]) begin errors++; nerr++; $display("FAIL alt_trace cyc=%0d got=%h want=%h", i, rec[i], expv[i]); end
    end
  endtask

  task automatic test_frame(input int per, input int maxrun, input bit long_run);
    int nerr = 0;
    int lt, fe_cnt, fe_at;
    do_reset(); clear_stim();
    gen_frame(192, maxrun);
    if (long_run) begin
      frame[99] = 1'b0; frame[124] = 1'b0;
      for (int b = 100; b < 124; b++) frame[b] = 1'b1;
    end
    add_level(1'b0, 40); add_bits(per, 192); add_level(frame[191], 40 * CPB);
    play(); build_expected();
    lt = last_edge_bit(192);
    checks++;
    if (st.size() != lt + IDLE_BITS) begin errors++; $display("FAIL frame%0d_strobe_total got=%0d want=%0d", per, st.size(), lt + IDLE_BITS); end
    if (st.size() >= 192) begin
      for (int j = 0; j < 192; j++) begin
        checks++;
        if (rec[st[j]][10] !== frame[j]) begin errors++; $display("FAIL frame%0d_bit%0d got=%b want=%b", per, j, rec[st[j]][10], frame[j]); end
      end
    end
    fe_cnt = 0; fe_at = -1;
    for (int i = 0; i < nline; i++) if (rec[i][9] === 1'b1) begin fe_cnt++; fe_at = i; end
    checks++;
    if (fe_cnt != 1) begin errors++; $display("FAIL frame%0d_end_count got=%0d want=1", per, fe_cnt); end
    if (st.size() > 0) begin
      checks++;
      if (fe_at != st[st.size()-1]) begin errors++; $display("FAIL frame%0d_end_at got=%0d want=%0d", per, fe_at, st[st.size()-1]); end
    end
    checks++;
    if (rec[nline-1][8] !== 1'b0) begin errors++; $display("FAIL frame%0d_active_after got=%b want=0", per, rec[nline-1][8]); end
    for (int i = 0; i < nline && nerr < 6; i++) begin
      checks++;
      if (rec[i] !== expv[i]) begin errors++; nerr++; $display("FAIL frame%0d_trace cyc=%0d got=%h want=%h", per, i, rec[i], expv[i]); end
    end
  endtask

  task automatic test_enable();
    int s40, up, late_sc, late_fe, late_fa;
    do_reset(); clear_stim();
    gen_frame(46, 5);
    add_level(1'b0, 40); add_bits(CPB, 46); add_level(frame[45], 80 * CPB);
    s40 = 40 + LAT + 39 * CPB;
    up  = s40 + 1 + 40 * CPB;
    for (int i = s40 + 1; i < up; i++) en_v[i] = 1'b0;
    play();
    checks++;
    if (rec[s40][11] !== 1'b1 || rec[s40][7:0] !== 8'd40) begin
      errors++; $display("FAIL en_bit40 got sc=%b cnt=%0d want sc=1 cnt=40", rec[s40][11], rec[s40][7:0]);
    end
    checks++;
    if (rec[s40+1] !== 12'h000) begin errors++; $display("FAIL en_drop_next got=%h want=000", rec[s40+1]); end
    late_sc = 0; late_fe = 0; late_fa = 0;
    for (int i = s40 + 1; i < nline; i++) begin
      if (rec[i][11] === 1'b1) late_sc++;
      if (rec[i][8] === 1'b1) late_fa++;
    end
    for (int i = 0; i < nline; i++) if (rec[i][9] === 1'b1) late_fe++;
    checks++; if (late_sc != 0) begin errors++; $display("FAIL en_strobes_after got=%0d want=0", late_sc); end
    checks++; if (late_fe != 0) begin errors++; $display("FAIL en_frame_end got=%0d want=0", late_fe); end
    checks++; if (late_fa != 0) begin errors++; $display("FAIL en_reenable_active got=%0d want=0", late_fa); end
  endtask

  task automatic test_glitch();
    int nerr = 0;
    int b, g;
    do_reset(); clear_stim();
    gen_frame(40, 5);
    add_level(1'b0, 40); add_bits(CPB, 40); add_level(frame[39], 40 * CPB);
    b = 40 + 10 * CPB;
    g = b + 5;
    line[g] = ~line[g];
    play(); build_expected();
    checks++;
    if (st.size() < 40) begin errors++; $display("FAIL glitch_strobe_total got=%0d want>=40", st.size()); end
    else begin
      for (int j = 0; j < 40; j++) begin
        checks++;
        if (rec[st[j]][10] !== frame[j]) begin errors++; $display("FAIL glitch_bit%0d got=%b want=%b", j, rec[st[j]][10], frame[j]); end
      end
      checks++;
      if (st[10] != (FILT ? b + LAT : g + 1 + LAT)) begin
        errors++; $display("FAIL glitch_shift got=%0d want=%0d", st[10], FILT ? b + LAT : g + 1 + LAT);
      end
    end
    for (int i = 0; i < nline && nerr < 6; i++) begin
      checks++;
      if (rec[i] !== expv[i]) begin errors++; nerr++; $display("FAIL glitch_trace cyc=%0d got=%h want=%h", i, rec[i], expv[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int s20;
    do_reset(); clear_stim();
    gen_frame(60, 5);
    add_level(1'b0, 40); add_bits(CPB, 60); add_level(frame[59], 10 * CPB);
    s20 = 40 + LAT + 20 * CPB;
    rst_v[s20] = 1'b1; rst_v[s20+1] = 1'b1;
    play();
    checks++;
    if (rec[s20 - CPB][11] !== 1'b1 || rec[s20 - CPB][8] !== 1'b1) begin
      errors++; $display("FAIL rstmid_locked got=%h want strobe+active", rec[s20 - CPB]);
    end
    checks++; if (rec[s20] !== 12'h000) begin errors++; $display("FAIL rstmid_drop got=%h want=000", rec[s20]); end
    checks++; if (rec[s20+1] !== 12'h000) begin errors++; $display("FAIL rstmid_hold got=%h want=000", rec[s20+1]); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_frame(CPB, 20, 1'b1);
    test_frame(15, 5, 1'b0);
    test_frame(17, 5, 1'b0);
    test_enable();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
